data_fifo: RTL

// - Parametrised synchronous FIFO with valid/ready handshakes on both sides.
// - Successor to the plain WIDTH-wide pass-through data blocks: adds a DEPTH

---
 rtl/data_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/data_fifo.sv
// data_fifo: parametrised synchronous FIFO with valid/ready handshakes on
// both sides, first-word fall-through output and a registered occupancy count.
// Optional feature: define DATA_FIFO_ALMOST_FULL_EN to add almost_full_o,
// asserted while the stored word count is at or above AF_THRESHOLD.
module data_fifo #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AF_THRESHOLD = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [WIDTH-1:0]             data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
`ifdef DATA_FIFO_ALMOST_FULL_EN
  ,
  output logic                         almost_full_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  if (DEPTH < 2) begin : g_depth_check
    $error("data_fifo: DEPTH must be at least 2");
  end

  if (WIDTH < 1) begin : g_width_check
    $error("data_fifo: WIDTH must be at least 1");
  end

`ifdef DATA_FIFO_ALMOST_FULL_EN
  if (AF_THRESHOLD < 1 || AF_THRESHOLD > DEPTH) begin : g_af_check
    $error("data_fifo: AF_THRESHOLD must lie in 1..DEPTH");
  end
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Handshake flags and outputs depend only on registered state.
  always_comb begin
    ready_o = (count_q != CNT_W'(DEPTH));
    valid_o = (count_q != '0);
    level_o = count_q;
    data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    push    = valid_i & ready_o;
    pop     = valid_o & ready_i;
  end

`ifdef DATA_FIFO_ALMOST_FULL_EN
  // Almost-full level taken from the registered count.
  always_comb begin
    almost_full_o = (count_q >= CNT_W'(AF_THRESHOLD));
  end
`endif

  // Next-state pointers and count; pointers wrap explicitly at DEPTH-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are left untouched by reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule
